// File: rtl/boron_pkg.sv
// Shared constants, S-box tables and FSM state type for the BORON-80 key schedule.
package boron_pkg;

  localparam int KEY_WIDTH  = 80;
  localparam int RK_WIDTH   = 64;
  localparam int ROT        = 13;
  localparam int NUM_ROUNDS = 25;
  localparam int IDX_WIDTH  = 5;
  localparam int RC_WIDTH   = 5;

  typedef logic [3:0] nibble_t;

  localparam nibble_t SBOX [16] = '{
    4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
  };

  localparam nibble_t SBOX_INV [16] = '{
    4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
    4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/boron_key_schedule_if.sv
// Round-key stream between the key schedule (master) and the round datapath (slave).
interface boron_key_schedule_if;
  import boron_pkg::*;

  logic [RK_WIDTH-1:0]  o_rk;
  logic                 o_rk_valid;
  logic                 i_rk_ready;
  logic [IDX_WIDTH-1:0] o_rk_idx;
  logic                 o_last;

  modport master (
    output o_rk, o_rk_valid, o_rk_idx, o_last,
    input  i_rk_ready
  );

  modport slave (
    input  o_rk, o_rk_valid, o_rk_idx, o_last,
    output i_rk_ready
  );

endinterface

// File: rtl/boron_key_step.sv
// One key-schedule step: forward F(K, rc) or inverse F^-1(K, rc), purely combinational.
module boron_key_step
  import boron_pkg::*;
#(
  parameter int ROT_BITS = boron_pkg::ROT
) (
  input  logic [KEY_WIDTH-1:0] i_k,
  input  logic [RC_WIDTH-1:0]  i_rc,
  input  logic                 i_inv,
  output logic [KEY_WIDTH-1:0] o_k
);

  logic [KEY_WIDTH-1:0] fwd;
  logic [KEY_WIDTH-1:0] inv_pre;
  logic [KEY_WIDTH-1:0] inv;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    fwd = {i_k[KEY_WIDTH-ROT_BITS-1:0], i_k[KEY_WIDTH-1:KEY_WIDTH-ROT_BITS]};
    fwd[3:0] = SBOX[fwd[3:0]];
    fwd[RK_WIDTH-1 -: RC_WIDTH] = fwd[RK_WIDTH-1 -: RC_WIDTH] ^ i_rc;

    // Inverse undoes the forward operations in reverse order.
    inv_pre = i_k;
    inv_pre[RK_WIDTH-1 -: RC_WIDTH] = inv_pre[RK_WIDTH-1 -: RC_WIDTH] ^ i_rc;
    inv_pre[3:0] = SBOX_INV[inv_pre[3:0]];
    inv = {inv_pre[ROT_BITS-1:0], inv_pre[KEY_WIDTH-1:ROT_BITS]};

    o_k = i_inv ? inv : fwd;
  end

endmodule

// File: rtl/boron_key_schedule.sv
// Streams round keys RK_0..RK_NUM_ROUNDS in encryption or decryption order from an 80-bit master key.
module boron_key_schedule #(
  parameter int NUM_ROUNDS = boron_pkg::NUM_ROUNDS,
  parameter int ROT        = boron_pkg::ROT
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_load,
  input  logic [boron_pkg::KEY_WIDTH-1:0] i_key,
  input  logic                            i_dec,
  boron_key_schedule_if.master            rk_if,
  output logic                            o_busy
);
  import boron_pkg::*;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ROUNDS);
  localparam logic [IDX_WIDTH-1:0] PREP_END = IDX_WIDTH'(NUM_ROUNDS - 1);

  state_t               state_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [KEY_WIDTH-1:0] key_next;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [IDX_WIDTH-1:0] cnt_q;
  logic [RC_WIDTH-1:0]  step_rc;
  logic                 step_inv;
  logic                 dec_q;
  logic                 valid_q;
  logic                 last_q;

  // PREP fast-forwards with rc = cnt+1; EMIT steps toward the next index in the chosen order.
  always_comb begin
    step_inv = 1'b0;
    step_rc  = cnt_q + 1'b1;
    if (state_q == ST_EMIT) begin
      step_inv = dec_q;
      step_rc  = dec_q ? idx_q : idx_q + 1'b1;
    end
  end

  boron_key_step #(.ROT_BITS(ROT)) u_step (
    .i_k   (key_q),
    .i_rc  (step_rc),
    .i_inv (step_inv),
    .o_k   (key_next)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      o_busy  <= 1'b0;
    end else if (i_load) begin
      // A load wins over everything, including a handshake completing this cycle.
      key_q   <= i_key;
      dec_q   <= i_dec;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      o_busy  <= 1'b1;
      state_q <= i_dec ? ST_PREP : ST_EMIT;
      valid_q <= !i_dec;
    end else begin
      unique case (state_q)
        ST_PREP: begin
          key_q <= key_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == PREP_END) begin
            state_q <= ST_EMIT;
            idx_q   <= LAST_IDX;
            valid_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (rk_if.i_rk_ready) begin
            if (last_q) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              o_busy  <= 1'b0;
            end else if (dec_q) begin
              key_q  <= key_next;
              idx_q  <= idx_q - 1'b1;
              last_q <= (idx_q == IDX_WIDTH'(1));
            end else begin
              key_q  <= key_next;
              idx_q  <= idx_q + 1'b1;
              last_q <= (idx_q == LAST_IDX - 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rk_if.o_rk       = key_q[RK_WIDTH-1:0];
  assign rk_if.o_rk_valid = valid_q;
  assign rk_if.o_rk_idx   = idx_q;
  assign rk_if.o_last     = last_q;

endmodule

// File: tb/tb_boron_key_schedule.sv
// Directed bench for boron_key_schedule: key streams checked against an independent step model.
module tb_boron_key_schedule;

  // S-box entry i sits at bits [4i+3:4i].
  localparam logic [63:0] SBOX_TBL = 64'h6358F02DAC971B4E;
  localparam logic [79:0] KEY_A    = 80'h0123456789ABCDEF0123;
  localparam logic [79:0] KEY_B    = 80'hFEDCBA9876543210A5C3;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_load;
  logic        i_dec;
  logic [79:0] i_key;
  logic        o_busy;

  boron_key_schedule_if rk_if();

  boron_key_schedule dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (i_load),
    .i_key   (i_key),
    .i_dec   (i_dec),
    .rk_if   (rk_if),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  logic [79:0] ref_k [26];
  logic [63:0] hand_rk [3] = '{64'h0000000000000000, 64'h080000000000000E, 64'h100000000001C00E};
  bit          zero_key;

  function automatic logic [79:0] model_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = (k << 13) | (k >> 67);
    t[3:0] = SBOX_TBL[4*t[3:0] +: 4];
    t[63:59] = t[63:59] ^ rc;
    return t;
  endfunction

  task automatic ref_gen(input logic [79:0] key);
    ref_k[0] = key;
    for (int i = 1; i < 26; i++) ref_k[i] = model_fwd(ref_k[i-1], 5'(i));
    zero_key = (key == 80'h0);
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic do_load(input logic [79:0] key, input logic dec);
    i_load = 1'b1;
    i_key  = key;
    i_dec  = dec;
    step();
    i_load = 1'b0;
  endtask

  task automatic expect_key(input int e, input bit dec);
    string t;
    t = $sformatf("%s idx%0d", dec ? "dec" : "enc", e);
    check({t, " valid"}, rk_if.o_rk_valid, 1);
    check({t, " idx"}, rk_if.o_rk_idx, e);
    check({t, " rk"}, rk_if.o_rk, ref_k[e][63:0]);
    check({t, " last"}, rk_if.o_last, dec ? (e == 0) : (e == 25));
    if (zero_key && e <= 2) check({t, " hand"}, rk_if.o_rk, hand_rk[e]);
  endtask

  task automatic wait_prep();
    for (int i = 0; i < 25; i++) begin
      check($sformatf("prep valid c%0d", i + 1), rk_if.o_rk_valid, 0);
      if (i == 12) check("prep busy", o_busy, 1);
      step();
    end
  endtask

  task automatic run_stream(input bit dec, input int bp_at);
    int e;
    for (int n = 0; n < 26; n++) begin
      e = dec ? 25 - n : n;
      expect_key(e, dec);
      if (e == bp_at) begin
        rk_if.i_rk_ready = 1'b0;
        repeat (3) begin
          step();
          expect_key(e, dec);
        end
        rk_if.i_rk_ready = 1'b1;
      end
      step();
    end
    check("end valid", rk_if.o_rk_valid, 0);
    check("end busy", o_busy, 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_load  = 1'b0;
    i_dec   = 1'b0;
    i_key   = '0;
    rk_if.i_rk_ready = 1'b1;
    #1;
    check("rst rk", rk_if.o_rk, 0);
    check("rst valid", rk_if.o_rk_valid, 0);
    check("rst idx", rk_if.o_rk_idx, 0);
    check("rst last", rk_if.o_last, 0);
    check("rst busy", o_busy, 0);
    step();
    i_rst_n = 1'b1;

    // Encryption, zero key, ready always high.
    ref_gen(80'h0);
    do_load(80'h0, 1'b0);
    run_stream(1'b0, -1);

    // Decryption, zero key: 25 silent PREP cycles, then descending stream.
    do_load(80'h0, 1'b1);
    wait_prep();
    run_stream(1'b1, -1);

    // Random key: encryption with a 3-cycle stall at idx 5, then decryption.
    ref_gen(KEY_A);
    do_load(KEY_A, 1'b0);
    run_stream(1'b0, 5);
    do_load(KEY_A, 1'b1);
    wait_prep();
    run_stream(1'b1, -1);

    // Reload at idx 10 of encryption with a decryption request.
    do_load(KEY_A, 1'b0);
    for (int e = 0; e < 10; e++) begin
      expect_key(e, 1'b0);
      step();
    end
    expect_key(10, 1'b0);
    do_load(KEY_B, 1'b1);
    ref_gen(KEY_B);
    wait_prep();
    run_stream(1'b1, -1);

    // Asynchronous reset mid-EMIT, away from any clock edge.
    do_load(KEY_B, 1'b0);
    for (int e = 0; e < 4; e++) begin
      expect_key(e, 1'b0);
      step();
    end
    #2 i_rst_n = 1'b0;
    #1;
    check("arst rk", rk_if.o_rk, 0);
    check("arst valid", rk_if.o_rk_valid, 0);
    check("arst idx", rk_if.o_rk_idx, 0);
    check("arst last", rk_if.o_last, 0);
    check("arst busy", o_busy, 0);
    step();
    i_rst_n = 1'b1;
    step();
    check("post-rst idle", o_busy, 0);
    ref_gen(80'h0);
    do_load(80'h0, 1'b0);
    run_stream(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boron_key_schedule.md
# boron_key_schedule

Sequential round-key generator for the BORON-80 datapath. It loads an 80-bit master key and streams the 26 round keys RK_0..RK_25 (25 rounds plus final whitening), one per handshake, to the round datapath. That datapath XORs each key into the state ahead of the S-box layer and the 64-bit permutation layer. It supports encryption order (RK_0 first) and decryption order (RK_25 first); decryption starts with a fast-forward pass.

## Interface
Parameters:
- NUM_ROUNDS, 25: number of cipher rounds. Round keys are indexed 0..NUM_ROUNDS.
- ROT, 13: left-rotation amount of the 80-bit key register per step.

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_load  input  1  one-cycle load strobe; captures i_key and i_dec.
- i_key  input  80  master key.
- i_dec  input  1  0 selects encryption order, 1 selects decryption order.
- o_rk  output  64  current round key, equal to K[63:0].
- o_rk_valid  output  1  o_rk is valid.
- i_rk_ready  input  1  consumer accepts o_rk.
- o_rk_idx  output  5  index of the key on o_rk.
- o_last  output  1  marks the final key of the sequence.
- o_busy  output  1  high in any state other than IDLE.

## Operation
Forward step F(K, rc), from K_i to K_(i+1) with rc = i+1:
- T = K rotated left by ROT over 80 bits.
- T[3:0] = SBOX(T[3:0]).
- T[63:59] ^= rc[4:0].

Inverse step F⁻¹(K, rc), from K_(i+1) to K_i:
- K[63:59] ^= rc.
- K[3:0] = SBOX_INV(K[3:0]).
- Rotate right by ROT.

S-box tables, entries 0..F:
- SBOX = E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
- SBOX_INV = A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B.

FSM states: IDLE, PREP, EMIT.
- IDLE, on i_load with i_dec=0: K = i_key, idx = 0, go to EMIT.
- IDLE, on i_load with i_dec=1: K = i_key, cnt = 0, go to PREP.
- PREP: each cycle K = F(K, cnt+1) and cnt++. After NUM_ROUNDS steps, idx = NUM_ROUNDS and go to EMIT.
- EMIT: o_rk_valid = 1. A transfer occurs when o_rk_valid && i_rk_ready.
- Encryption transfer: if idx == NUM_ROUNDS go to IDLE; otherwise K = F(K, idx+1) and idx++.
- Decryption transfer: if idx == 0 go to IDLE; otherwise K = F⁻¹(K, idx) and idx--.
- o_last = EMIT && (idx == NUM_ROUNDS for encryption, idx == 0 for decryption).

Boundary rules:
- i_load in any state, including PREP and EMIT, aborts the current sequence and restarts from the new key in the same edge. Any pending transfer in that cycle is discarded.
- No valid is issued during PREP.
- Backpressure: while valid && !ready, o_rk, o_rk_idx and o_last hold stable.
- Asynchronous reset mid-sequence clears all state immediately.
- The rc XOR touches only bits 63:59. Bits 79:64 are updated only by rotation.

## Timing
- Reset values: o_rk = 0, o_rk_valid = 0, o_rk_idx = 0, o_last = 0, o_busy = 0, state = IDLE, K = 0.
- Encryption: RK_0 is valid the cycle after i_load. With ready held high, the sequence is 26 keys in 26 consecutive cycles, and o_busy falls the cycle after the RK_25 transfer.
- Decryption: PREP lasts NUM_ROUNDS = 25 cycles, so RK_25 is valid 26 cycles after i_load. Then 26 keys follow in descending order.
- All outputs are driven from registers. There is no combinational path from i_rk_ready to o_rk.
- A new i_load is accepted back-to-back in the cycle after the last transfer.

## Structure
- The package boron_pkg holds:
  - SBOX and SBOX_INV as 16×4 constant arrays;
  - KEY_WIDTH = 80, RK_WIDTH = 64, ROT = 13, NUM_ROUNDS = 25;
  - the FSM state enum.
- Sub-module boron_key_step is combinational. Ports: i_k[79:0], i_rc[4:0], i_inv, o_k[79:0]. It implements F and F⁻¹ and is instantiated once, with i_inv selected by the FSM.
- The FSM, counters and key register live in boron_key_schedule.

## Test plan
- Encryption, zero key, ready held high:
  - RK_0 = 0x0000000000000000 at idx 0.
  - RK_1 = 0x080000000000000E at idx 1.
  - 26 transfers in total, o_last only at idx 25, then o_busy = 0.
- Decryption, zero key:
  - no valid for 25 cycles after load;
  - first key idx 25, equal to the encryption RK_25;
  - idx 1 = 0x080000000000000E;
  - last key idx 0 = 0 with o_last = 1.
- Random key (e.g. 0x0123456789ABCDEF0123): decryption stream equals the reversed encryption stream for all 26 keys.
- Backpressure: drop i_rk_ready for 3 cycles at idx 5. Outputs must stay stable and idx must not skip; the resumed stream must match the ready-high reference.
- i_load at idx 10 of encryption with a new key and i_dec=1: PREP restarts and the old sequence produces no further valid.
- Assert i_rst_n low asynchronously mid-EMIT: all outputs go to 0 without a clock edge, and a subsequent load behaves normally.
